// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer for a 1-bit ALU slice: shifts operands LSB first through
// the slice, recirculates its carry and reassembles a WIDTH-bit result with flags.
module serial_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_less,
   output logic             slice_ainvert,
   output logic             slice_binvert,
   output logic             slice_cin,
   output logic [1:0]       slice_op,
   input  logic             slice_result,
   input  logic             slice_cout,
   input  logic             slice_set,
   input  logic             slice_overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [1:0]       op_r;
   logic             ainv_r;
   logic             binv_r;
   logic             slt_r;
   logic             arith_r;
   logic             set_cap;
   logic             ovf_cap;

   logic [1:0] dec_op;
   logic       dec_ainv;
   logic       dec_binv;
   logic       dec_slt;
   logic       dec_arith;

   // Unlisted control codes fall through to the ADD decode.
   always_comb begin
      dec_op    = 2'b10;
      dec_ainv  = 1'b0;
      dec_binv  = 1'b0;
      dec_slt   = 1'b0;
      dec_arith = 1'b0;
      case (alu_ctrl)
         4'b0000: dec_op = 2'b00;
         4'b0001: dec_op = 2'b01;
         4'b0110: begin
            dec_binv  = 1'b1;
            dec_arith = 1'b1;
         end
         4'b0111: begin
            dec_op   = 2'b11;
            dec_binv = 1'b1;
            dec_slt  = 1'b1;
         end
         4'b1100: begin
            dec_op   = 2'b00;
            dec_ainv = 1'b1;
            dec_binv = 1'b1;
         end
         default: dec_arith = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_shift  <= '0;
         b_shift  <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         op_r     <= 2'b00;
         ainv_r   <= 1'b0;
         binv_r   <= 1'b0;
         slt_r    <= 1'b0;
         arith_r  <= 1'b0;
         set_cap  <= 1'b0;
         ovf_cap  <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_shift <= src_a;
                  b_shift <= src_b;
                  op_r    <= dec_op;
                  ainv_r  <= dec_ainv;
                  binv_r  <= dec_binv;
                  slt_r   <= dec_slt;
                  arith_r <= dec_arith;
                  carry   <= dec_binv;
                  cnt     <= '0;
                  result  <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               result  <= {slice_result, result[WIDTH-1:1]};
               carry   <= slice_cout;
               a_shift <= a_shift >> 1;
               b_shift <= b_shift >> 1;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  set_cap <= slice_set;
                  ovf_cap <= slice_overflow;
                  state   <= slt_r ? FIX : DONE;
               end
            end
            FIX: begin
               // Sign of the difference corrected for overflow gives signed less-than.
               result[0] <= set_cap ^ ovf_cap;
               state     <= DONE;
            end
            default: begin
               done     <= 1'b1;
               zero     <= (result == '0);
               overflow <= arith_r & ovf_cap;
               state    <= IDLE;
            end
         endcase
      end
   end

   logic run;
   assign run = (state == RUN);

   assign busy          = run || (state == FIX);
   assign slice_a       = run & a_shift[0];
   assign slice_b       = run & b_shift[0];
   assign slice_cin     = run & carry;
   assign slice_ainvert = run & ainv_r;
   assign slice_binvert = run & binv_r;
   assign slice_op      = run ? op_r : 2'b00;
   assign slice_less    = 1'b0;

endmodule
